fifo_rd_ptr_ctrl: RTL and testbench
===================================

Name: fifo_rd_ptr_ctrl

Overview:
Read-side pointer and flag controller for the team's dual-clock FIFO; the counterpart of the write-pointer controller.
- Lives entirely in the read clock domain.
- Brings the Gray-coded write pointer across domains through a multi-flop synchronizer.
- Keeps the binary read pointer, drives the RAM read address and exports a registered Gray read pointer back to the write side.
- Generates empty, almost_empty, fill count and underflow indication.

Parameters:
N, 4, pointer width including wrap bit; FIFO depth = 2^(N-1)
SYNC_STAGES, 2, flops in write-pointer synchronizer chain (>=2)
AE_THRESH, 1, almost_empty asserted when rd_count <= AE_THRESH

Ports:
clk  in  1  read-domain clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
read  in  1  read request from consumer
g_wr_ptr_async  in  N  Gray write pointer from write domain (asynchronous)
g_rd_ptr  out  N  registered Gray read pointer, to write-domain synchronizer
rd_addr  out  N-1  binary RAM read address = b_rd_ptr[N-2:0]
rd_en  out  1  read accepted this cycle (read && !empty), RAM read strobe
empty  out  1  FIFO empty as seen in read domain
almost_empty  out  1  rd_count <= AE_THRESH
rd_count  out  N  words available, 0..2^(N-1)
underflow  out  1  one-cycle pulse, cycle after a read attempted while empty

Behaviour:
- Reset: the clock is clk; the reset is reset, synchronous and active-low (reset==0 sampled at posedge clk). On reset:
  - b_rd_ptr=0, g_rd_ptr=0, all sync stages=0, underflow=0.
  - Resulting outputs: rd_addr=0, empty=1, almost_empty=1, rd_count=0, rd_en=0.
- Synchronizer: sync[0]<=g_wr_ptr_async; sync[i]<=sync[i-1]; g_wr_sync=sync[SYNC_STAGES-1]. No logic between stages.
- b_wr_sync = Gray-to-binary(g_wr_sync), combinational: b[N-1]=g[N-1]; b[i]=b[i+1]^g[i].
- empty = (b_wr_sync == b_rd_ptr), all N bits compared; combinational from registered values.
- rd_count = (b_wr_sync - b_rd_ptr) mod 2^N. Range 0..2^(N-1). A value > 2^(N-1) cannot occur in legal operation and is not checked.
- rd_en = read && !empty, combinational.
- Pointer update:
  - On rd_en: b_rd_ptr <= b_rd_ptr+1, mod 2^N wrap, no saturation.
  - Otherwise b_rd_ptr holds.
- g_rd_ptr is a register loaded with bin2gray(next b_rd_ptr), i.e. it changes in the same edge as b_rd_ptr. Only one bit toggles per increment, and it is never driven combinationally.
- underflow <= read && empty, registered. High exactly one cycle after each rejected read. Pointer unchanged.
- Latency:
  - A change on g_wr_ptr_async, stable before an edge, reaches empty/rd_count after SYNC_STAGES edges (2 by default).
  - Read-pointer effect on g_rd_ptr: 1 edge.
- Pessimism: empty may stay asserted up to SYNC_STAGES cycles after a write. empty never deasserts early, so no data is read before it is written.
- Wrap-around: b_rd_ptr 2^N-1 -> 0. Gray (N=4) 1000 -> 0000. rd_addr 7 -> 0. The MSB difference with the write pointer correctly distinguishes a full FIFO (count 8) from an empty one.
- Simultaneous read and incoming write on the same edge: the read is decided on the current empty. The new write pointer is seen SYNC_STAGES cycles later.
- Reset mid-operation: all state returns to reset values on the next edge regardless of read. The write side must be reset concurrently; mismatched resets are out of scope.

Test Plan:
- Reset with g_wr_ptr_async=0, read=1 -> empty=1, rd_count=0, rd_en=0; underflow=1 in the cycle after the first rejected read; g_rd_ptr=0000.
- Drive g_wr_ptr_async=0011 (binary 2) -> empty=0 and rd_count=2 exactly 2 edges later, never earlier.
- Continuous read after that: rd_en=1 for 2 cycles, rd_addr 0,1; then empty=1, rd_count=0. g_rd_ptr sequence 0001, 0011.
- Wrap: step write Gray 0..15..0 with reads interleaved to drain.
  - b_rd_ptr 15->0, g_rd_ptr 1000->0000, rd_addr 7->0.
  - Check one-bit Gray change every increment.
- Full-level count: g_wr_ptr_async = Gray(8) = 1100 with rd ptr 0 -> rd_count=8, empty=0 (not empty despite equal low bits); almost_empty=0.
- almost_empty: rd_count=1 -> almost_empty=1; rd_count=2 -> almost_empty=0.
- Reset asserted while rd_count=5 and read=1 -> next edge: b_rd_ptr=0, syncs=0, empty=1, underflow=0.

Source files
------------

// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-side pointer/flag controller for the dual-clock FIFO (read clock domain).
// Synchronizes the Gray write pointer, owns the read pointer and derives empty/count/underflow.
module fifo_rd_ptr_ctrl #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         read_i,
    input  logic [N-1:0] g_wr_ptr_async_i,
    output logic [N-1:0] g_rd_ptr_o,
    output logic [N-2:0] rd_addr_o,
    output logic         rd_en_o,
    output logic         empty_o,
    output logic         almost_empty_o,
    output logic [N-1:0] rd_count_o,
    output logic         underflow_o
);

    localparam logic [N-1:0] AE_LIM = N'(AE_THRESH);

    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] g_wr_sync;
    logic [N-1:0] b_wr_sync;
    logic [N-1:0] b_rd_ptr_q, b_rd_ptr_d;
    logic [N-1:0] g_rd_ptr_q, g_rd_ptr_d;
    logic         underflow_q, underflow_d;

    // Plain flop chain: no logic between stages so each bit settles independently.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= g_wr_ptr_async_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign g_wr_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        b_wr_sync = '0;
        for (int i = 0; i < N; i++) b_wr_sync[i] = ^(g_wr_sync >> i);
    end

    assign rd_count_o     = b_wr_sync - b_rd_ptr_q;
    assign empty_o        = (b_wr_sync == b_rd_ptr_q);
    assign almost_empty_o = (rd_count_o <= AE_LIM);
    assign rd_en_o        = read_i && !empty_o;

    always_comb begin
        b_rd_ptr_d  = rd_en_o ? b_rd_ptr_q + 1'b1 : b_rd_ptr_q;
        g_rd_ptr_d  = b_rd_ptr_d ^ (b_rd_ptr_d >> 1);
        underflow_d = read_i && empty_o;
    end

    // Gray pointer is registered from the next binary value so it moves on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            b_rd_ptr_q  <= '0;
            g_rd_ptr_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            b_rd_ptr_q  <= b_rd_ptr_d;
            g_rd_ptr_q  <= g_rd_ptr_d;
            underflow_q <= underflow_d;
        end
    end

    assign g_rd_ptr_o  = g_rd_ptr_q;
    assign rd_addr_o   = b_rd_ptr_q[N-2:0];
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Self-checking bench for fifo_rd_ptr_ctrl: cycle model feeding a scoreboard queue,
// plus directed checks for latency, wrap, full-level count and reset.
module tb_fifo_rd_ptr_ctrl;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         read_i;
    logic [N-1:0] g_wr_ptr_async_i;
    logic [N-1:0] g_rd_ptr_o;
    logic [N-2:0] rd_addr_o;
    logic         rd_en_o;
    logic         empty_o;
    logic         almost_empty_o;
    logic [N-1:0] rd_count_o;
    logic         underflow_o;

    int checks   = 0;
    int failures = 0;
    int wraps    = 0;

    typedef struct {
        logic [N-1:0] g_rd;
        logic [N-2:0] addr;
        logic         rd_en;
        logic         empty;
        logic         ae;
        logic [N-1:0] cnt;
        logic         under;
    } exp_t;

    exp_t sb_q[$];

    fifo_rd_ptr_ctrl #(.N(N), .SYNC_STAGES(2), .AE_THRESH(1)) dut (
        .clk              (clk),
        .reset            (reset),
        .read_i           (read_i),
        .g_wr_ptr_async_i (g_wr_ptr_async_i),
        .g_rd_ptr_o       (g_rd_ptr_o),
        .rd_addr_o        (rd_addr_o),
        .rd_en_o          (rd_en_o),
        .empty_o          (empty_o),
        .almost_empty_o   (almost_empty_o),
        .rd_count_o       (rd_count_o),
        .underflow_o      (underflow_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [N-1:0] from_gray(input logic [N-1:0] g);
        logic [N-1:0] b;
        b[N-1] = g[N-1];
        for (int i = N-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Reference model: advanced at each rising edge, expected outputs pushed to the scoreboard.
    logic [N-1:0] m_s0, m_s1, m_brd;
    logic         m_under;

    always @(posedge clk) begin
        exp_t         e;
        logic [N-1:0] cnt;
        cnt = from_gray(m_s1) - m_brd;
        if (!reset) begin
            m_s0 = '0; m_s1 = '0; m_brd = '0; m_under = 1'b0;
        end else begin
            m_under = read_i && (cnt == 0);
            if (read_i && cnt != 0) m_brd = m_brd + 1'b1;
            m_s1 = m_s0;
            m_s0 = g_wr_ptr_async_i;
        end
        cnt     = from_gray(m_s1) - m_brd;
        e.g_rd  = to_gray(m_brd);
        e.addr  = m_brd[N-2:0];
        e.empty = (cnt == 0);
        e.rd_en = read_i && (cnt != 0);
        e.ae    = (cnt <= 1);
        e.cnt   = cnt;
        e.under = m_under;
        sb_q.push_back(e);
    end

    logic [N-1:0] prev_g;
    logic [N-2:0] prev_addr;
    logic         prev_valid = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq("sb_g_rd",    g_rd_ptr_o,     e.g_rd);
            check_eq("sb_rd_addr", rd_addr_o,      e.addr);
            check_eq("sb_rd_en",   rd_en_o,        e.rd_en);
            check_eq("sb_empty",   empty_o,        e.empty);
            check_eq("sb_ae",      almost_empty_o, e.ae);
            check_eq("sb_count",   rd_count_o,     e.cnt);
            check_eq("sb_under",   underflow_o,    e.under);
            if (prev_valid && reset && g_rd_ptr_o != prev_g) begin
                check_eq("gray_1bit", $countones(g_rd_ptr_o ^ prev_g), 1);
                if (prev_addr == 3'd7) begin
                    check_eq("wrap_addr", rd_addr_o, 0);
                    if (prev_g == 4'b1000) begin
                        check_eq("wrap_gray", g_rd_ptr_o, 0);
                        wraps++;
                    end
                end
            end
            prev_g     = g_rd_ptr_o;
            prev_addr  = rd_addr_o;
            prev_valid = reset;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; read_i = 1'b1; g_wr_ptr_async_i = '0;
        tick(3);
        check_eq("rst_empty", empty_o, 1);
        check_eq("rst_count", rd_count_o, 0);
        check_eq("rst_rd_en", rd_en_o, 0);
        check_eq("rst_g_rd",  g_rd_ptr_o, 0);
        check_eq("rst_under", underflow_o, 0);

        reset = 1'b1;
        tick(1);
        check_eq("under_pulse", underflow_o, 1);
        read_i = 1'b0;
        tick(1);
        check_eq("under_clear", underflow_o, 0);

        g_wr_ptr_async_i = 4'b0011;
        tick(1);
        check_eq("lat1_empty", empty_o, 1);
        check_eq("lat1_count", rd_count_o, 0);
        tick(1);
        check_eq("lat2_empty", empty_o, 0);
        check_eq("lat2_count", rd_count_o, 2);

        read_i = 1'b1;
        #1;
        check_eq("rd0_en",   rd_en_o, 1);
        check_eq("rd0_addr", rd_addr_o, 0);
        tick(1);
        check_eq("rd1_en",   rd_en_o, 1);
        check_eq("rd1_addr", rd_addr_o, 1);
        check_eq("rd1_g",    g_rd_ptr_o, 4'b0001);
        tick(1);
        check_eq("drain_g",     g_rd_ptr_o, 4'b0011);
        check_eq("drain_empty", empty_o, 1);
        check_eq("drain_count", rd_count_o, 0);
        read_i = 1'b0;

        // Step the write pointer one word at a time around the whole Gray cycle.
        for (int k = 0; k < 16; k++) begin
            g_wr_ptr_async_i = to_gray(4'(3 + k));
            tick(3);
            check_eq("step_count", rd_count_o, 1);
            read_i = 1'b1;
            tick(1);
            read_i = 1'b0;
            tick(1);
            check_eq("step_empty", empty_o, 1);
        end
        check_eq("wrap_seen", wraps, 1);

        reset = 1'b0; g_wr_ptr_async_i = '0;
        tick(1);
        reset = 1'b1;
        g_wr_ptr_async_i = 4'b0001;
        tick(3);
        check_eq("ae_cnt1", rd_count_o, 1);
        check_eq("ae_1",    almost_empty_o, 1);
        g_wr_ptr_async_i = 4'b0011;
        tick(3);
        check_eq("ae_cnt2", rd_count_o, 2);
        check_eq("ae_2",    almost_empty_o, 0);
        g_wr_ptr_async_i = 4'b0111;
        tick(3);
        check_eq("mid_cnt5", rd_count_o, 5);

        reset = 1'b0; read_i = 1'b1;
        tick(1);
        check_eq("mid_rst_empty", empty_o, 1);
        check_eq("mid_rst_count", rd_count_o, 0);
        check_eq("mid_rst_under", underflow_o, 0);
        check_eq("mid_rst_g",     g_rd_ptr_o, 0);
        check_eq("mid_rst_addr",  rd_addr_o, 0);
        read_i = 1'b0; g_wr_ptr_async_i = '0;
        tick(1);
        reset = 1'b1;
        g_wr_ptr_async_i = 4'b1100;
        tick(3);
        check_eq("full_count", rd_count_o, 8);
        check_eq("full_empty", empty_o, 0);
        check_eq("full_ae",    almost_empty_o, 0);
        read_i = 1'b1;
        tick(1);
        read_i = 1'b0;
        check_eq("full_minus1", rd_count_o, 7);
        tick(2);
        check_eq("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
